// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the I2C master and its CRC helper.
// Holds FSM state codes, CRC-8 parameters and the read length.
package i2c_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_ACK   = 3'd3,
      ST_WRITE = 3'd4,
      ST_READ  = 3'd5,
      ST_MACK  = 3'd6,
      ST_STOP  = 3'd7
   } state_e;

   localparam logic [7:0] CRC_POLY = 8'h31;
   localparam logic [7:0] CRC_INIT = 8'hFF;
   localparam logic [3:0] N_BYTES  = 4'd6;

   function automatic logic [7:0] crc8_byte(
      input logic [7:0] crc,
      input logic [7:0] data
   );
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
         else      c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/i2c_crc8.sv
// Byte-serial CRC-8 calculator (poly 0x31, init 0xFF).
// clr has priority over upd.
module i2c_crc8
   import i2c_master_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       upd,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);

   logic [7:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr)      crc_d = CRC_INIT;
      else if (upd) crc_d = crc8_byte(crc_q, data_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= CRC_INIT;
      else        crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/i2c_master.sv
// Open-drain I2C master: command write, optional wait, then a
// six-byte read with per-word CRC-8 checking.
module i2c_master
   import i2c_master_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 250,
   parameter int unsigned MEAS_WAIT = 2_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Processor_Ready,
   input  logic       r_or_w,
   input  logic [6:0] Peripheral_Address,
   input  logic [7:0] Command_Data_Frames,
   inout  wire        Sda_Data,
   inout  wire        Scl_Data,
   output logic [2:0] Master_State_Out,
   output logic       i2c_writes,
   output logic [7:0] Data_Received,
   output logic [3:0] Bytes_Received,
   output logic [3:0] Output_Received_Counter,
   output logic       Frames_Read,
   output logic [3:0] SHT_Reads,
   output logic       CRC_Error
);

   localparam int DW = $clog2(CLK_DIV) + 1;

   state_e      state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]  phase_q, phase_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [6:0]  addr_q, addr_d;
   logic [7:0]  cmd_q, cmd_d;
   logic        rw_q, rw_d;
   logic        rd_q, rd_d;
   logic        pend_q, pend_d;
   logic        data_ph_q, data_ph_d;
   logic        nack_q, nack_d;
   logic [31:0] wait_q, wait_d;
   logic        sda_oe_q, sda_oe_d;
   logic        scl_oe_q, scl_oe_d;
   logic        sda_s1_q, sda_s2_q;
   logic        wr_q, wr_d;
   logic [7:0]  data_q, data_d;
   logic [3:0]  bytes_q, bytes_d;
   logic [3:0]  orc_q, orc_d;
   logic        frames_q, frames_d;
   logic [3:0]  sht_q, sht_d;
   logic        crc_err_q, crc_err_d;
   logic        crc_clr, crc_upd, tick;
   logic [7:0]  crc_val;

   i2c_crc8 u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (crc_clr),
      .upd    (crc_upd),
      .data_i (shift_q),
      .crc_o  (crc_val)
   );

   assign tick = (div_q == DW'(CLK_DIV - 1));

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      rw_d      = rw_q;
      rd_d      = rd_q;
      pend_d    = pend_q;
      data_ph_d = data_ph_q;
      nack_d    = nack_q;
      wait_d    = wait_q;
      sda_oe_d  = sda_oe_q;
      scl_oe_d  = scl_oe_q;
      wr_d      = 1'b0;
      data_d    = data_q;
      bytes_d   = bytes_q;
      orc_d     = orc_q;
      frames_d  = 1'b0;
      sht_d     = sht_q;
      crc_err_d = crc_err_q;
      crc_clr   = 1'b0;
      crc_upd   = 1'b0;

      if (state_q == ST_IDLE) begin
         div_d    = '0;
         phase_d  = 2'd0;
         sda_oe_d = 1'b0;
         scl_oe_d = 1'b0;
         if (pend_q) begin
            if (wait_q != 32'd0) begin
               wait_d = wait_q - 32'd1;
            end else begin
               pend_d    = 1'b0;
               rd_d      = 1'b1;
               data_ph_d = 1'b0;
               shift_d   = {addr_q, 1'b1};
               bytes_d   = 4'd0;
               crc_err_d = 1'b0;
               crc_clr   = 1'b1;
               state_d   = ST_START;
            end
         end else if (Processor_Ready) begin
            addr_d    = Peripheral_Address;
            cmd_d     = Command_Data_Frames;
            rw_d      = r_or_w;
            rd_d      = 1'b0;
            data_ph_d = 1'b0;
            shift_d   = {Peripheral_Address, 1'b0};
            state_d   = ST_START;
         end
      end else begin
         div_d = tick ? '0 : div_q + DW'(1);
         if (tick) begin
            phase_d = phase_q + 2'd1;
            unique case (phase_q)
               2'd0: scl_oe_d = 1'b0;
               2'd1: begin
                  case (state_q)
                     ST_START: sda_oe_d = 1'b1;
                     ST_STOP:  sda_oe_d = 1'b0;
                     ST_ACK:   nack_d   = sda_s2_q;
                     ST_READ:  shift_d  = {shift_q[6:0], sda_s2_q};
                     default: ;
                  endcase
               end
               2'd2: if (state_q != ST_STOP) scl_oe_d = 1'b1;
               2'd3: begin
                  case (state_q)
                     ST_START: begin
                        state_d  = ST_ADDR;
                        bit_d    = 3'd0;
                        sda_oe_d = ~shift_q[7];
                     end
                     ST_ADDR, ST_WRITE: begin
                        if (bit_q == 3'd7) begin
                           state_d   = ST_ACK;
                           sda_oe_d  = 1'b0;
                           data_ph_d = (state_q == ST_WRITE);
                        end else begin
                           bit_d    = bit_q + 3'd1;
                           shift_d  = {shift_q[6:0], 1'b0};
                           sda_oe_d = ~shift_q[6];
                        end
                     end
                     ST_ACK: begin
                        if (nack_q) begin
                           state_d  = ST_STOP;
                           sda_oe_d = 1'b1;
                           pend_d   = 1'b0;
                        end else if (data_ph_q) begin
                           state_d  = ST_STOP;
                           sda_oe_d = 1'b1;
                           wr_d     = 1'b1;
                           pend_d   = rw_q;
                        end else if (rd_q) begin
                           state_d  = ST_READ;
                           bit_d    = 3'd0;
                           sda_oe_d = 1'b0;
                        end else begin
                           state_d  = ST_WRITE;
                           bit_d    = 3'd0;
                           shift_d  = cmd_q;
                           sda_oe_d = ~cmd_q[7];
                        end
                     end
                     ST_READ: begin
                        if (bit_q == 3'd7) begin
                           state_d  = ST_MACK;
                           data_d   = shift_q;
                           bytes_d  = bytes_q + 4'd1;
                           orc_d    = orc_q + 4'd1;
                           sda_oe_d = (bytes_q != N_BYTES - 4'd1);
                           // third byte of each word is the CRC of the first two
                           if (bytes_q == 4'd2 || bytes_q == 4'd5) begin
                              crc_clr = 1'b1;
                              if (crc_val != shift_q) crc_err_d = 1'b1;
                           end else begin
                              crc_upd = 1'b1;
                           end
                        end else begin
                           bit_d = bit_q + 3'd1;
                        end
                     end
                     ST_MACK: begin
                        if (bytes_q == N_BYTES) begin
                           state_d  = ST_STOP;
                           sda_oe_d = 1'b1;
                           frames_d = 1'b1;
                           sht_d    = sht_q + 4'd1;
                        end else begin
                           state_d  = ST_READ;
                           bit_d    = 3'd0;
                           sda_oe_d = 1'b0;
                        end
                     end
                     ST_STOP: begin
                        state_d  = ST_IDLE;
                        sda_oe_d = 1'b0;
                        scl_oe_d = 1'b0;
                        if (pend_q) wait_d = MEAS_WAIT;
                     end
                     default: ;
                  endcase
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         phase_q   <= 2'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'd0;
         addr_q    <= 7'd0;
         cmd_q     <= 8'd0;
         rw_q      <= 1'b0;
         rd_q      <= 1'b0;
         pend_q    <= 1'b0;
         data_ph_q <= 1'b0;
         nack_q    <= 1'b0;
         wait_q    <= 32'd0;
         sda_oe_q  <= 1'b0;
         scl_oe_q  <= 1'b0;
         sda_s1_q  <= 1'b1;
         sda_s2_q  <= 1'b1;
         wr_q      <= 1'b0;
         data_q    <= 8'd0;
         bytes_q   <= 4'd0;
         orc_q     <= 4'd0;
         frames_q  <= 1'b0;
         sht_q     <= 4'd0;
         crc_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         cmd_q     <= cmd_d;
         rw_q      <= rw_d;
         rd_q      <= rd_d;
         pend_q    <= pend_d;
         data_ph_q <= data_ph_d;
         nack_q    <= nack_d;
         wait_q    <= wait_d;
         sda_oe_q  <= sda_oe_d;
         scl_oe_q  <= scl_oe_d;
         sda_s1_q  <= Sda_Data;
         sda_s2_q  <= sda_s1_q;
         wr_q      <= wr_d;
         data_q    <= data_d;
         bytes_q   <= bytes_d;
         orc_q     <= orc_d;
         frames_q  <= frames_d;
         sht_q     <= sht_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign Sda_Data = sda_oe_q ? 1'b0 : 1'bz;
   assign Scl_Data = scl_oe_q ? 1'b0 : 1'bz;

   assign Master_State_Out        = state_q;
   assign i2c_writes              = wr_q;
   assign Data_Received           = data_q;
   assign Bytes_Received          = bytes_q;
   assign Output_Received_Counter = orc_q;
   assign Frames_Read             = frames_q;
   assign SHT_Reads               = sht_q;
   assign CRC_Error               = crc_err_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural I2C slave
// that returns a fixed six-byte sensor frame.
module tb_i2c_master;

   logic       clk;
   logic       rst_n;
   logic       Processor_Ready;
   logic       r_or_w;
   logic [6:0] Peripheral_Address;
   logic [7:0] Command_Data_Frames;
   wire        sda;
   wire        scl;
   logic [2:0] Master_State_Out;
   logic       i2c_writes;
   logic [7:0] Data_Received;
   logic [3:0] Bytes_Received;
   logic [3:0] Output_Received_Counter;
   logic       Frames_Read;
   logic [3:0] SHT_Reads;
   logic       CRC_Error;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int fr_cnt = 0;

   logic       slv_oe  = 1'b0;
   logic       slv_en  = 1'b1;
   logic       slv_ack = 1'b1;
   logic [7:0] rd_data [6];
   logic [7:0] wr_addr = 8'h00;
   logic [7:0] rd_addr = 8'h00;
   logic [7:0] cmd_byte = 8'h00;
   logic [5:0] mack = 6'h00;

   pullup (sda);
   pullup (scl);
   assign sda = (slv_oe && slv_en) ? 1'b0 : 1'bz;

   i2c_master #(.CLK_DIV(4), .MEAS_WAIT(20)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .Processor_Ready         (Processor_Ready),
      .r_or_w                  (r_or_w),
      .Peripheral_Address      (Peripheral_Address),
      .Command_Data_Frames     (Command_Data_Frames),
      .Sda_Data                (sda),
      .Scl_Data                (scl),
      .Master_State_Out        (Master_State_Out),
      .i2c_writes              (i2c_writes),
      .Data_Received           (Data_Received),
      .Bytes_Received          (Bytes_Received),
      .Output_Received_Counter (Output_Received_Counter),
      .Frames_Read             (Frames_Read),
      .SHT_Reads               (SHT_Reads),
      .CRC_Error               (CRC_Error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && i2c_writes)  wr_cnt <= wr_cnt + 1;
      if (rst_n && Frames_Read) fr_cnt <= fr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic slv_rx(output logic [7:0] b);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         @(posedge scl);
         b = {b[6:0], sda};
      end
   endtask

   task automatic slv_do_ack();
      @(negedge scl);
      slv_oe = 1'b1;
      @(negedge scl);
      slv_oe = 1'b0;
   endtask

   task automatic slv_tx(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         slv_oe = ~d[i];
         @(negedge scl);
      end
      slv_oe = 1'b0;
   endtask

   initial begin : slave
      logic [7:0] b;
      forever begin
         do @(negedge sda); while (scl !== 1'b1);
         slv_rx(b);
         if (slv_ack) begin
            slv_do_ack();
            if (b[0]) begin
               rd_addr = b;
               for (int k = 0; k < 6; k++) begin
                  slv_tx(rd_data[k]);
                  @(posedge scl);
                  mack[k] = sda;
                  @(negedge scl);
               end
            end else begin
               wr_addr = b;
               slv_rx(b);
               cmd_byte = b;
               slv_do_ack();
            end
         end
      end
   end

   task automatic start_txn(input logic [6:0] a, input logic [7:0] c,
                            input logic rw);
      @(negedge clk);
      Peripheral_Address  = a;
      Command_Data_Frames = c;
      r_or_w              = rw;
      Processor_Ready     = 1'b1;
      @(negedge clk);
      Processor_Ready     = 1'b0;
   endtask

   task automatic wait_idle(input int legs, input string tag);
      logic late;
      int cyc;
      late = 1'b0;
      for (int k = 0; k < legs; k++) begin
         cyc = 0;
         while (Master_State_Out == 3'd0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
         end
         while (Master_State_Out != 3'd0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
         end
         if (cyc >= 4000) late = 1'b1;
      end
      check(tag, late, 1'b0);
   endtask

   initial begin : stim
      int cyc;
      rd_data[0] = 8'hBE; rd_data[1] = 8'hEF; rd_data[2] = 8'h92;
      rd_data[3] = 8'h66; rd_data[4] = 8'h66; rd_data[5] = 8'h93;
      rst_n = 1'b0;
      Processor_Ready = 1'b0;
      r_or_w = 1'b0;
      Peripheral_Address = 7'h00;
      Command_Data_Frames = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_state", Master_State_Out, 0);
      check("rst_sht", SHT_Reads, 0);
      check("rst_data", Data_Received, 0);
      check("rst_sda", sda, 1);
      check("rst_scl", scl, 1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_scl", scl, 1);

      // write-only transaction
      start_txn(7'h55, 8'hAA, 1'b0);
      wait_idle(1, "wr_timeout");
      check("wr_addr", wr_addr, 8'hAA);
      check("wr_cmd", cmd_byte, 8'hAA);
      check("wr_pulses", wr_cnt, 1);
      check("wr_state", Master_State_Out, 0);
      check("wr_sht", SHT_Reads, 0);
      check("wr_orc", Output_Received_Counter, 0);

      // write then good read
      start_txn(7'h55, 8'hAA, 1'b1);
      wait_idle(2, "rd_timeout");
      check("rd_addr", rd_addr, 8'hAB);
      check("rd_wr_pulses", wr_cnt, 2);
      check("rd_crc_err", CRC_Error, 0);
      check("rd_frames", fr_cnt, 1);
      check("rd_sht", SHT_Reads, 1);
      check("rd_orc", Output_Received_Counter, 6);
      check("rd_data", Data_Received, 8'h93);
      check("rd_bytes", Bytes_Received, 6);
      check("rd_mack", mack, 6'b100000);

      // bad RH CRC
      rd_data[5] = 8'h00;
      start_txn(7'h55, 8'hAA, 1'b1);
      wait_idle(2, "crc_timeout");
      check("crc_err", CRC_Error, 1);
      check("crc_sht", SHT_Reads, 2);
      check("crc_orc", Output_Received_Counter, 12);
      check("crc_data", Data_Received, 8'h00);
      check("crc_frames", fr_cnt, 2);

      // no slave: NACK on address
      slv_ack = 1'b0;
      start_txn(7'h55, 8'hAA, 1'b0);
      wait_idle(1, "nack_timeout");
      check("nack_state", Master_State_Out, 0);
      check("nack_wr", wr_cnt, 3);
      check("nack_sht", SHT_Reads, 2);
      check("nack_crc_sticky", CRC_Error, 1);
      check("nack_scl", scl, 1);

      // run the read counter round to wrap
      slv_ack = 1'b1;
      rd_data[5] = 8'h93;
      for (int t = 0; t < 13; t++) begin
         start_txn(7'h55, 8'hAA, 1'b1);
         wait_idle(2, "wrap_timeout");
      end
      check("sht_15", SHT_Reads, 15);
      check("crc_cleared", CRC_Error, 0);
      start_txn(7'h55, 8'hAA, 1'b1);
      wait_idle(2, "wrap_timeout");
      check("sht_wrap", SHT_Reads, 0);
      check("orc_wrap", Output_Received_Counter, 0);
      check("wrap_frames", fr_cnt, 16);

      // asynchronous reset during third read byte
      start_txn(7'h55, 8'hAA, 1'b1);
      cyc = 0;
      while (Bytes_Received != 4'd2 && cyc < 8000) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_timeout", cyc < 8000, 1);
      repeat (2) @(negedge scl);
      #1;
      check("mid_state", Master_State_Out, 5);
      slv_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("ar_state", Master_State_Out, 0);
      check("ar_scl", scl, 1);
      check("ar_sda", sda, 1);
      check("ar_bytes", Bytes_Received, 0);
      check("ar_data", Data_Received, 0);
      check("ar_orc", Output_Received_Counter, 0);
      check("ar_crc", CRC_Error, 0);
      check("ar_wr", i2c_writes, 0);
      check("ar_fr", Frames_Read, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_state", Master_State_Out, 0);
      check("post_scl", scl, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 250: system clocks per SCL quarter-period; bit period = 4*CLK_DIV clocks.
REQ-002 Parameter MEAS_WAIT, default 2_500_000: idle clocks between the command write and the read-back (sensor measurement time).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 Processor_Ready  in  1  level request to run a transaction; sampled only in IDLE.
REQ-006 r_or_w  in  1  1 = command write then 6-byte read; 0 = command write only.
REQ-007 Peripheral_Address  in  7  target 7-bit I2C address.
REQ-008 Command_Data_Frames  in  8  command byte written after the address.
REQ-009 Sda_Data  inout  1  open-drain SDA: drives 0 or Z, never 1.
REQ-010 Scl_Data  inout  1  open-drain SCL: drives 0 or Z, never 1.
REQ-011 Master_State_Out  out  3  current FSM state code.
REQ-012 i2c_writes  out  1  one-clock pulse when the command byte is ACKed.
REQ-013 Data_Received  out  8  last byte read, MSB first.
REQ-014 Bytes_Received  out  4  bytes read in the current read transaction, 0..6.
REQ-015 Output_Received_Counter  out  4  increments mod 16 each time Data_Received updates.
REQ-016 Frames_Read  out  1  one-clock pulse after the 6th byte and CRC checks.
REQ-017 SHT_Reads  out  4  completed read transactions, wraps 15->0.
REQ-018 CRC_Error  out  1  sticky until next read start; set on any CRC mismatch.

Function
REQ-019 FSM states and codes: IDLE=0, START=1, ADDR=2, ACK=3, WRITE=4, READ=5, MACK=6, STOP=7.
REQ-020 Bit timing: phase0 SCL low, SDA updated; phase1 SCL released; phase2 SDA sampled; phase3 SCL pulled low.
REQ-021 START: SDA falls while SCL released. STOP: SDA rises while SCL released. SCL stays released in IDLE.
REQ-022 ADDR sends {Peripheral_Address, rw bit} MSB first; rw = 0 for write, 1 for read.
REQ-023 ACK samples SDA at phase2 of the 9th bit; high (NACK) -> STOP then IDLE, no counters change, no i2c_writes pulse.
REQ-024 Write sequence: START, ADDR(w), ACK, WRITE(Command_Data_Frames), ACK, STOP; then MEAS_WAIT clocks in IDLE-coded wait if r_or_w=1, else IDLE.
REQ-025 Read sequence: START, ADDR(r), ACK, six READ bytes each followed by MACK; master drives ACK(0) after bytes 1-5, NACK(Z) after byte 6; then STOP.
REQ-026 Read byte order: T_msb, T_lsb, T_crc, RH_msb, RH_lsb, RH_crc.
REQ-027 CRC-8: poly 0x31, init 0xFF, no reflection, no final XOR, over each 2-byte word; mismatch sets CRC_Error.
REQ-028 At read start: Bytes_Received <= 0, CRC_Error <= 0.
REQ-029 Frames_Read pulses and SHT_Reads increments in the cycle the FSM enters STOP after byte 6.
REQ-030 Processor_Ready held high -> a new transaction starts one clock after returning to IDLE.
REQ-031 Processor_Ready deasserted mid-transaction is ignored; the transaction completes.
REQ-032 No clock-stretching support; SCL is never sampled.

Reset
REQ-033 rst_n low: state IDLE, SDA and SCL released (Z), all outputs 0, all counters and shift registers 0, CRC register 0xFF; takes effect immediately regardless of clk.
REQ-034 Reset mid-transaction abandons the bus with both lines released; no STOP generated.

Structure
REQ-035 Shared package holds the state-code enum, the CRC polynomial/init constants and the byte-count constant 6.
REQ-036 One sub-module, i2c_crc8: byte-serial CRC-8 calculator with clear and update inputs.

Verification
REQ-037 Address 0x55, command 0xAA, r_or_w=0, slave ACKs -> SDA bytes 0xAA then 0xAA, one i2c_writes pulse, STOP, IDLE.
REQ-038 Same with r_or_w=1, slave returns BE EF 92 66 66 93 -> read address byte 0xAB, CRC_Error=0, Frames_Read pulse, SHT_Reads=1, Output_Received_Counter +6.
REQ-039 Return RH_crc 0x00 instead of 0x93 -> CRC_Error=1 after byte 6, SHT_Reads still increments.
REQ-040 No slave (SDA pulled up) -> NACK at ACK, STOP, IDLE, SHT_Reads and i2c_writes unchanged.
REQ-041 rst_n low during READ byte 3 -> all outputs 0, SDA/SCL Z within the same clock; release -> IDLE.
REQ-042 16 successful read transactions -> SHT_Reads wraps to 0.
